// File: rtl/ahb3lite_sdram_wrbuf.sv
// rtl/ahb3lite_sdram_wrbuf.sv - write-combining line buffer feeding the SDRAM command sequencer
// Gathers byte-masked writes into one aligned line, then drains it as a single masked burst.
module ahb3lite_sdram_wrbuf #(
  parameter int HADDR_SIZE   = 20,
  parameter int HDATA_SIZE   = 32,
  parameter int BUFFER_WORDS = 8,
  parameter int TIMEOUT_SIZE = 8
)(
  input  logic                    HCLK,
  input  logic                    PRESETn,
  input  logic [TIMEOUT_SIZE-1:0] timeout_i,
  input  logic                    wr_req_i,
  input  logic [HADDR_SIZE-1:0]   wr_adr_i,
  input  logic [HDATA_SIZE/8-1:0] wr_be_i,
  input  logic [HDATA_SIZE-1:0]   wr_dat_i,
  output logic                    wr_ready_o,
  input  logic                    flush_i,
  output logic                    flush_req_o,
  output logic [HADDR_SIZE-1:0]   flush_adr_o,
  input  logic                    flush_ack_i,
  input  logic                    rd_en_i,
  output logic [HDATA_SIZE-1:0]   rd_dat_o,
  output logic [HDATA_SIZE/8-1:0] rd_be_o,
  output logic                    empty_o
);
  localparam int BE_SIZE  = HDATA_SIZE / 8;
  localparam int LB       = $clog2(BUFFER_WORDS * BE_SIZE);
  localparam int WB       = $clog2(BUFFER_WORDS);
  localparam int TAG_SIZE = HADDR_SIZE - LB;

  typedef enum logic [1:0] {EMPTY, FILL, FLUSH, DRAIN} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [TAG_SIZE-1:0]     r_tag;
  logic [HDATA_SIZE-1:0]   r_data [BUFFER_WORDS];
  logic [BE_SIZE-1:0]      r_valid [BUFFER_WORDS];
  logic [TIMEOUT_SIZE-1:0] r_timer;
  logic [WB-1:0]           r_ptr;

  logic [TAG_SIZE-1:0]     w_tag;
  logic [WB-1:0]           w_widx;
  logic                    w_tag_hit;
  logic                    w_accept;
  logic                    w_full;
  logic                    w_timeout;
  logic                    w_last;
  logic                    w_unused;

  assign w_tag     = wr_adr_i[HADDR_SIZE-1:LB];
  assign w_widx    = wr_adr_i[LB-1 -: WB];
  assign w_unused  = ^wr_adr_i[LB-WB-1:0];
  assign w_tag_hit = (w_tag == r_tag);
  assign w_accept  = wr_req_i & wr_ready_o;
  assign w_last    = (r_ptr == WB'(BUFFER_WORDS - 1));

  // The idle timer fires on the edge where it would count down to zero.
  assign w_timeout = (timeout_i != '0) && !w_accept && (r_timer <= TIMEOUT_SIZE'(1));

  always_comb begin
    w_full = 1'b1;
    for (int i = 0; i < BUFFER_WORDS; i++)
      if (r_valid[i] != '1) w_full = 1'b0;
  end

  always_ff @(posedge HCLK or posedge PRESETn) begin
    if (PRESETn) r_state <= EMPTY;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      EMPTY: if (w_accept) w_next = FILL;
      FILL:  if ((wr_req_i && !w_tag_hit) || flush_i || w_full || w_timeout) w_next = FLUSH;
      FLUSH: if (flush_ack_i) w_next = DRAIN;
      DRAIN: if (rd_en_i && w_last) w_next = EMPTY;
      default: w_next = EMPTY;
    endcase
  end

  always_comb begin
    wr_ready_o  = 1'b0;
    flush_req_o = 1'b0;
    empty_o     = 1'b0;
    rd_dat_o    = '0;
    rd_be_o     = '0;
    case (r_state)
      EMPTY: begin
        wr_ready_o = 1'b1;
        empty_o    = 1'b1;
      end
      FILL:  wr_ready_o  = w_tag_hit;
      FLUSH: flush_req_o = 1'b1;
      DRAIN: begin
        rd_dat_o = r_data[r_ptr];
        rd_be_o  = r_valid[r_ptr];
      end
      default: ;
    endcase
  end

  assign flush_adr_o = {r_tag, {LB{1'b0}}};

  always_ff @(posedge HCLK or posedge PRESETn) begin
    if (PRESETn) begin
      r_tag   <= '0;
      r_timer <= '0;
      r_ptr   <= '0;
      for (int i = 0; i < BUFFER_WORDS; i++) r_valid[i] <= '0;
    end else begin
      if (w_accept) begin
        r_tag           <= w_tag;
        r_timer         <= timeout_i;
        r_valid[w_widx] <= r_valid[w_widx] | wr_be_i;
      end else if (r_state == FILL && r_timer != '0) begin
        r_timer <= r_timer - TIMEOUT_SIZE'(1);
      end
      if (r_state == FLUSH && flush_ack_i) r_ptr <= '0;
      if (r_state == DRAIN && rd_en_i) begin
        r_ptr <= r_ptr + WB'(1);
        if (w_last)
          for (int i = 0; i < BUFFER_WORDS; i++) r_valid[i] <= '0;
      end
    end
  end

  // Data bytes are qualified by r_valid, so they need no reset.
  always_ff @(posedge HCLK) begin
    if (w_accept)
      for (int b = 0; b < BE_SIZE; b++)
        if (wr_be_i[b]) r_data[w_widx][8*b +: 8] <= wr_dat_i[8*b +: 8];
  end
endmodule

// File: doc/ahb3lite_sdram_wrbuf.md
Name: ahb3lite_sdram_wrbuf

Overview:
Write-combining line buffer between the AHB port slave and the SDRAM command sequencer inside ahb3lite_sdram_ctrl. It collects byte-masked AHB writes into one aligned line of BUFFER_WORDS words, holds them until a flush condition, then hands the line to the sequencer as one SDRAM write burst with per-byte masks. Flush conditions are line complete, idle timeout, write to another line, and explicit request.

Parameters:
HADDR_SIZE, 20, byte address width
HDATA_SIZE, 32, data word width; power of 2, >=8
BUFFER_WORDS, 8, words per line; power of 2, >=2
TIMEOUT_SIZE, 8, width of idle-timeout field

Ports:
HCLK  in  1  clock, all logic on rising edge
PRESETn  in  1  reset, asynchronous, active-high (asserted when 1)
timeout_i  in  TIMEOUT_SIZE  idle cycles before auto-flush; 0 = timeout disabled
wr_req_i  in  1  write request from AHB slave
wr_adr_i  in  HADDR_SIZE  byte address of write
wr_be_i  in  HDATA_SIZE/8  byte enables
wr_dat_i  in  HDATA_SIZE  write data, byte lanes per wr_be_i
wr_ready_o  out  1  write accepted this cycle when wr_req_i & wr_ready_o
flush_i  in  1  force flush (e.g. read hit on buffered line)
flush_req_o  out  1  line ready for sequencer
flush_adr_o  out  HADDR_SIZE  line base address (low log2(BUFFER_WORDS*HDATA_SIZE/8) bits zero)
flush_ack_i  in  1  sequencer accepts line
rd_en_i  in  1  sequencer consumes current word
rd_dat_o  out  HDATA_SIZE  current drain word
rd_be_o  out  HDATA_SIZE/8  byte mask of current word (0 = do not write, drives DQM)
empty_o  out  1  no valid bytes held

Behaviour:
- Reset: state EMPTY; all valid-byte flags 0; timer 0; rd pointer 0; wr_ready_o=1, flush_req_o=0, flush_adr_o=0, rd_dat_o=0, rd_be_o=0, empty_o=1. Reset mid-drain discards line.
- Line tag = wr_adr_i[HADDR_SIZE-1:LB], LB = log2(BUFFER_WORDS*HDATA_SIZE/8); word index = next log2(BUFFER_WORDS) bits below LB.
- States: EMPTY, FILL, FLUSH, DRAIN.
- EMPTY: wr_ready_o=1. Accepted write -> latch tag, merge data, set valid bits, load timer = timeout_i, -> FILL. flush_i ignored.
- FILL: write with same tag: wr_ready_o=1, merged in 1 cycle (only bytes with be=1 overwrite; valid |= be), timer reloaded. Write with different tag: wr_ready_o=0 (combinational on tag compare), -> FLUSH; write stays stalled until back in EMPTY.
- FILL -> FLUSH also when: all valid bits set (after the completing write's edge); timer reaches 0 with timeout_i!=0 (timer decrements each cycle without accepted write); flush_i=1. Simultaneous same-tag write and flush_i: write merged first, then FLUSH.
- FLUSH: wr_ready_o=0, flush_req_o=1, flush_adr_o=tag<<LB. flush_ack_i -> DRAIN, rd pointer=0, flush_req_o drops next cycle.
- DRAIN: rd_dat_o/rd_be_o = word[ptr]/valid[ptr] combinationally. rd_en_i advances ptr. rd_en_i at ptr=BUFFER_WORDS-1 -> clear all valid, -> EMPTY (wr_ready_o=1 next cycle). rd_en_i outside DRAIN ignored.
- empty_o=1 only in EMPTY. Buffer never accepts writes in FLUSH/DRAIN.
- Minimum write-to-flush_req latency: 1 cycle after the triggering event edge.

Test Plan:
- 8 sequential word writes 0x100..0x11C, be=0xF, data 0xA0..0xA7 -> flush_req_o rises after 8th, flush_adr_o=0x100; drain yields A0..A7, rd_be_o=0xF all.
- timeout_i=8, single byte write 0x205 be=0x2 data 0x0000_5A00 -> 8 idle cycles later flush_req_o=1, adr 0x200; word1 be=0x2, others be=0.
- Two writes to 0x300 be=0x3 (0x1111) then be=0xC (0x2222_0000) -> word0 =0x2222_1111, be=0xF.
- Write 0x400 then write 0x420 -> wr_ready_o=0 until line 0x400 drained, then 0x420 accepted; second flush adr 0x420.
- flush_i with write to same line in same cycle -> write merged, then flush; flush_i in EMPTY -> no flush_req_o.
- PRESETn=1 during DRAIN at ptr=3 -> all outputs to reset values, empty_o=1; subsequent write accepted normally.
